game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter N_OBS, default 8, number of obstacles managed.
REQ-002 SHALL have parameter WIN_HOLD, default 120, frames the WIN/LOSE screen is held.
REQ-003 SHALL have parameter TIME_LIMIT, default 3600, frames allowed in PLAY before LOSE.
REQ-004 SHALL have port clk  input  1  system clock; one clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per frame at vblank start.
REQ-007 SHALL have port fire  input  1  fire button level, already synchronised to clk.
REQ-008 SHALL have port hit  input  N_OBS  per-obstacle bullet/obstacle pixel overlap, level, active video only.
REQ-009 SHALL have port bullet_top  input  1  bullet has left the top of the screen, level.
REQ-010 SHALL have port obs_en  output  N_OBS  alive mask gating each obstacle's obs_on.
REQ-011 SHALL have port launch  output  1  one-cycle pulse that starts a new bullet.
REQ-012 SHALL have port bullet_active  output  1  a bullet is in flight.
REQ-013 SHALL have port score  output  8  obstacles destroyed this game.
REQ-014 SHALL have port state  output  2  IDLE=0, PLAY=1, WIN=2, LOSE=3.

Function
REQ-015 SHALL derive fire_rise as fire high this cycle and low the previous cycle.
REQ-016 SHALL in IDLE hold obs_en=0 and bullet_active=0, and on fire_rise go to PLAY with obs_en=all ones, score=0, frame counter=0; that fire_rise SHALL NOT launch.
REQ-017 SHALL in PLAY, on fire_rise with bullet_active=0, assert launch for exactly one cycle and set bullet_active=1 the next cycle.
REQ-018 SHALL ignore fire_rise while bullet_active=1, with no queuing.
REQ-019 SHALL OR (hit & obs_en) into a hit accumulator every cycle of PLAY.
REQ-020 SHALL latch bullet_top into a top flag every cycle of PLAY.
REQ-021 SHALL include a hit or bullet_top sampled in the same cycle as frame_tick in that frame's update.
REQ-022 SHALL on frame_tick in PLAY set obs_en to obs_en & ~acc.
REQ-023 SHALL on frame_tick in PLAY add popcount(acc) to score, saturating at 255.
REQ-024 SHALL on frame_tick in PLAY clear bullet_active if acc!=0 or the top flag is set, clear acc and the top flag, and increment the frame counter.
REQ-025 SHALL apply frame_tick and fire_rise in the same cycle in the order: frame update first, then launch eligibility evaluated on the pre-update bullet_active.
REQ-026 SHALL ignore hits on obstacles whose obs_en bit is 0; they neither score nor count.
REQ-027 SHALL go to WIN when the post-update obs_en is zero.
REQ-028 SHALL go to LOSE when the frame counter reaches TIME_LIMIT with obs_en nonzero; WIN takes priority if both hold in one update.
REQ-029 SHALL in WIN/LOSE hold score, force bullet_active=0 and launch=0, count WIN_HOLD frame_ticks, then go to IDLE.
REQ-030 SHALL NOT change state on fire in WIN/LOSE.
REQ-031 SHALL register all outputs; obs_en, score and state change the cycle after frame_tick.

Reset
REQ-032 SHALL on reset set state=IDLE, obs_en=0, score=0, launch=0, bullet_active=0, and clear the accumulator, top flag, counters and the fire edge register.
REQ-033 SHALL give reset priority over every event in the same cycle.
REQ-034 SHALL abandon the game and return to IDLE on reset asserted mid-PLAY, with no launch pulse.

Structure
REQ-035 SHALL place the state encoding and the default N_OBS, WIN_HOLD and TIME_LIMIT constants in shared package space_pkg.
REQ-036 SHALL use one sub-module, edge_det, a registered rising-edge detector also reusable for the led inputs.
REQ-037 SHALL implement popcount as a combinational function inside game_ctrl.

Verification
REQ-038 SHALL cover: reset, then fire pulse -> state=1, obs_en=8'hFF, score=0, no launch pulse.
REQ-039 SHALL cover: in PLAY, fire pulse -> launch high exactly 1 cycle; second fire pulse before frame_tick -> no launch.
REQ-040 SHALL cover: hit=8'b0000_0101 for 3 cycles, then frame_tick -> obs_en=8'hFA, score=2, bullet_active=0 one cycle after the tick.
REQ-041 SHALL cover: hit=8'h01 again on the dead obstacle 0, then frame_tick -> score unchanged, obs_en unchanged.
REQ-042 SHALL cover: kill all 8, then frame_tick -> state=2; after 120 frame_ticks -> state=0, obs_en=0.
REQ-043 SHALL cover: with TIME_LIMIT=4 and no hits, 4 frame_ticks -> state=3; reset asserted in PLAY alongside frame_tick and hit -> state=0, score=0.

Source files
------------

// File: rtl/space_pkg.sv
// ============================================================================
// Module   : space_pkg
// Brief    : Shared game state encoding and default game constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package space_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    localparam int N_OBS_DEF      = 8;
    localparam int WIN_HOLD_DEF   = 120;
    localparam int TIME_LIMIT_DEF = 3600;

endpackage

`default_nettype wire

// File: rtl/game_ctrl_edge_det.sv
// ============================================================================
// Module   : edge_det
// Brief    : Rising-edge detector; compares the input against its registered copy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

`default_nettype wire

// File: rtl/game_ctrl.sv
// ============================================================================
// Module   : game_ctrl
// Brief    : Game flow controller: obstacle alive mask, bullet launch, scoring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_ctrl
    import space_pkg::*;
#(
    parameter int N_OBS      = N_OBS_DEF,
    parameter int WIN_HOLD   = WIN_HOLD_DEF,
    parameter int TIME_LIMIT = TIME_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             fire,
    input  logic [N_OBS-1:0] hit,
    input  logic             bullet_top,
    output logic [N_OBS-1:0] obs_en,
    output logic             launch,
    output logic             bullet_active,
    output logic [7:0]       score,
    output logic [1:0]       state
);

    // One counter serves both the play timer and the end-screen hold.
    localparam int CNT_MAX = (TIME_LIMIT > WIN_HOLD) ? TIME_LIMIT : WIN_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    function automatic logic [8:0] popcount(input logic [N_OBS-1:0] v);
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < N_OBS; i++) begin
            c = c + 9'(v[i]);
        end
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [N_OBS-1:0]  obs_en_q, obs_en_d;
    logic [N_OBS-1:0]  acc_q, acc_d;
    logic              top_q, top_d;
    logic [7:0]        score_q, score_d;
    logic              launch_q, launch_d;
    logic              bact_q, bact_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              fire_rise;
    logic [N_OBS-1:0]  acc_now;
    logic              top_now;
    logic [N_OBS-1:0]  obs_post;
    logic [8:0]        score_sum;
    logic [CW-1:0]     cnt_inc;

    edge_det u_fire_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (fire),
        .rise_o (fire_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            obs_en_q <= '0;
            acc_q    <= '0;
            top_q    <= 1'b0;
            score_q  <= '0;
            launch_q <= 1'b0;
            bact_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            obs_en_q <= obs_en_d;
            acc_q    <= acc_d;
            top_q    <= top_d;
            score_q  <= score_d;
            launch_q <= launch_d;
            bact_q   <= bact_d;
            cnt_q    <= cnt_d;
        end
    end

    // Current-cycle hit/top samples join the frame update that happens now.
    assign acc_now   = acc_q | (hit & obs_en_q);
    assign top_now   = top_q | bullet_top;
    assign obs_post  = obs_en_q & ~acc_now;
    assign score_sum = {1'b0, score_q} + popcount(acc_now);
    assign cnt_inc   = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        obs_en_d = obs_en_q;
        acc_d    = acc_q;
        top_d    = top_q;
        score_d  = score_q;
        launch_d = 1'b0;
        bact_d   = bact_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                obs_en_d = '0;
                bact_d   = 1'b0;
                acc_d    = '0;
                top_d    = 1'b0;
                if (fire_rise) begin
                    state_d  = ST_PLAY;
                    obs_en_d = '1;
                    score_d  = '0;
                    cnt_d    = '0;
                end
            end
            ST_PLAY: begin
                acc_d = acc_now;
                top_d = top_now;
                if (frame_tick) begin
                    obs_en_d = obs_post;
                    score_d  = (score_sum > 9'd255) ? 8'hFF : score_sum[7:0];
                    if ((acc_now != '0) || top_now) begin
                        bact_d = 1'b0;
                    end
                    acc_d = '0;
                    top_d = 1'b0;
                    cnt_d = cnt_inc;
                    if (obs_post == '0) begin
                        state_d = ST_WIN;
                        cnt_d   = '0;
                    end else if (cnt_inc == CW'(TIME_LIMIT)) begin
                        state_d = ST_LOSE;
                        cnt_d   = '0;
                    end
                end
                // Eligibility uses the pre-update flag; no launch if the game just ended.
                if (fire_rise && !bact_q && (state_d == ST_PLAY)) begin
                    launch_d = 1'b1;
                    bact_d   = 1'b1;
                end
            end
            default: begin
                bact_d = 1'b0;
                acc_d  = '0;
                top_d  = 1'b0;
                if (frame_tick) begin
                    if (cnt_inc == CW'(WIN_HOLD)) begin
                        state_d  = ST_IDLE;
                        obs_en_d = '0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
        endcase
    end

    assign obs_en        = obs_en_q;
    assign launch        = launch_q;
    assign bullet_active = bact_q;
    assign score         = score_q;
    assign state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// ============================================================================
// Module   : tb_game_ctrl
// Brief    : Directed + random bench for game_ctrl against a frame-level game model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_ctrl;

    localparam int NO = 8;
    localparam int WH = 120;
    localparam int TL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_tick = 1'b0;
    logic          fire = 1'b0;
    logic [NO-1:0] hit = '0;
    logic          bullet_top = 1'b0;
    logic [NO-1:0] obs_en;
    logic          launch;
    logic          bullet_active;
    logic [7:0]    score;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;

    // Reference game model
    int         m_state = 0;
    logic [7:0] m_alive = '0;
    logic [7:0] m_acc = '0;
    bit         m_top = 0;
    int         m_score = 0;
    bit         m_bullet = 0;
    bit         m_launch = 0;
    int         m_frames = 0;
    int         m_hold = 0;
    bit         m_prev_fire = 0;

    game_ctrl #(.N_OBS(NO), .WIN_HOLD(WH), .TIME_LIMIT(TL)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .fire          (fire),
        .hit           (hit),
        .bullet_top    (bullet_top),
        .obs_en        (obs_en),
        .launch        (launch),
        .bullet_active (bullet_active),
        .score         (score),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit ft, input bit fi,
                              input logic [7:0] h, input bit bt);
        bit         rise;
        bit         b0;
        logic [7:0] killed;
        rise     = fi && !m_prev_fire;
        m_launch = 0;
        if (rst) begin
            m_state = 0; m_alive = '0; m_acc = '0; m_top = 0; m_score = 0;
            m_bullet = 0; m_frames = 0; m_hold = 0; m_prev_fire = 0;
            return;
        end
        m_prev_fire = fi;
        if (m_state == 0) begin
            m_alive = '0; m_bullet = 0; m_acc = '0; m_top = 0;
            if (rise) begin
                m_state = 1; m_alive = 8'hFF; m_score = 0; m_frames = 0;
            end
        end else if (m_state == 1) begin
            b0    = m_bullet;
            m_acc = m_acc | (h & m_alive);
            m_top = m_top | bt;
            if (ft) begin
                killed  = m_acc;
                m_alive = m_alive & ~killed;
                m_score = m_score + $countones(killed);
                if (m_score > 255) m_score = 255;
                if (killed != 0 || m_top) m_bullet = 0;
                m_acc = '0;
                m_top = 0;
                m_frames++;
                if (m_alive == 0) begin
                    m_state = 2; m_hold = 0;
                end else if (m_frames == TL) begin
                    m_state = 3; m_hold = 0;
                end
            end
            if (rise && !b0 && m_state == 1) begin
                m_launch = 1; m_bullet = 1;
            end
        end else begin
            m_bullet = 0; m_acc = '0; m_top = 0;
            if (ft) begin
                m_hold++;
                if (m_hold == WH) begin
                    m_state = 0; m_alive = '0;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance model, then compare all outputs.
    task automatic step(input bit rst, input bit ft, input bit fi,
                        input logic [7:0] h, input bit bt);
        reset = rst; frame_tick = ft; fire = fi; hit = h; bullet_top = bt;
        @(posedge clk);
        model_step(rst, ft, fi, h, bt);
        #1;
        chk("state",  32'(state),         32'(m_state));
        chk("obs_en", 32'(obs_en),        32'(m_alive));
        chk("score",  32'(score),         32'(m_score));
        chk("launch", 32'(launch),        32'(m_launch));
        chk("bullet", 32'(bullet_active), 32'(m_bullet));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, '0, 0);
            step(0, 0, 0, '0, 0);
        end
    endtask

    initial begin
        #2;
        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_obs", 32'(obs_en), 32'd0);
        step(0, 0, 0, '0, 0);

        // Start game: the starting fire must not launch
        step(0, 0, 1, '0, 0);
        chk("start_state", 32'(state), 32'd1);
        chk("start_obs", 32'(obs_en), 32'hFF);
        chk("start_score", 32'(score), 32'd0);
        step(0, 0, 1, '0, 0);
        chk("start_nolaunch", 32'(launch), 32'd0);
        step(0, 0, 0, '0, 0);

        // Launch, then a second fire while in flight is ignored
        step(0, 0, 1, '0, 0);
        chk("launch_pulse", 32'(launch), 32'd1);
        step(0, 0, 0, '0, 0);
        chk("launch_once", 32'(launch), 32'd0);
        chk("bullet_on", 32'(bullet_active), 32'd1);
        step(0, 0, 1, '0, 0);
        chk("refire_ignored", 32'(launch), 32'd0);
        step(0, 0, 0, '0, 0);

        // Hits on obstacles 0 and 2
        repeat (3) step(0, 0, 0, 8'b0000_0101, 0);
        step(0, 1, 0, '0, 0);
        chk("hit_obs", 32'(obs_en), 32'hFA);
        chk("hit_score", 32'(score), 32'd2);
        chk("hit_bullet", 32'(bullet_active), 32'd0);

        // Dead obstacle hit does nothing
        repeat (3) step(0, 0, 0, 8'h01, 0);
        step(0, 1, 0, '0, 0);
        chk("dead_score", 32'(score), 32'd2);
        chk("dead_obs", 32'(obs_en), 32'hFA);

        // Kill remaining on the tick cycle itself -> WIN
        step(0, 1, 0, 8'hFA, 0);
        chk("win_state", 32'(state), 32'd2);
        chk("win_score", 32'(score), 32'd8);
        step(0, 0, 1, '0, 0);
        chk("win_fire", 32'(state), 32'd2);
        step(0, 0, 0, '0, 0);
        ticks(WH);
        chk("win_idle", 32'(state), 32'd0);
        chk("win_idle_obs", 32'(obs_en), 32'd0);

        // Timeout -> LOSE
        step(0, 0, 1, '0, 0);
        step(0, 0, 0, '0, 0);
        ticks(TL);
        chk("lose_state", 32'(state), 32'd3);
        ticks(WH);
        chk("lose_idle", 32'(state), 32'd0);

        // Reset mid-PLAY alongside tick, hit and fire
        step(0, 0, 1, '0, 0);
        step(0, 0, 0, 8'h10, 0);
        step(0, 1, 0, 8'h01, 0);
        chk("pre_rst_score", 32'(score), 32'd2);
        step(1, 1, 1, 8'hFF, 1);
        chk("rst_play_state", 32'(state), 32'd0);
        chk("rst_play_score", 32'(score), 32'd0);
        chk("rst_play_launch", 32'(launch), 32'd0);

        // Random play
        for (int i = 0; i < 8000; i++) begin
            bit         r_rst, r_ft, r_fi, r_bt;
            logic [7:0] r_h;
            r_rst = ($urandom_range(0, 999) == 0);
            r_ft  = ($urandom_range(0, 3) == 0);
            r_fi  = ($urandom_range(0, 2) == 0) ? ~fire : fire;
            r_h   = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : '0;
            r_bt  = ($urandom_range(0, 15) == 0);
            step(r_rst, r_ft, r_fi, r_h, r_bt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
